watchdog_supervisor: RTL and testbench
======================================

Name: watchdog_supervisor

Overview:
- Windowed watchdog controller built around a CNT_W-bit up-counter.
- Sequences arm, closed window, open window, warning and expiry. Accepts keyed kicks and accepts configuration only while disabled.
- Raises a warning interrupt before the hard timeout.
- Sits between the software kick interface and the system reset-request logic.

Parameters:
- CNT_W, 4, counter and configuration width.
- KEY_W, 8, kick key width.
- KICK_KEY, 8'hA5, only key value accepted as a valid kick.
- GRACE, 4, cycles spent in WARN before expiry; must be >= 1.
- LOCK_EN, 1, when 1, enable deassertion is ignored once armed.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arm request, level-sensitive.
- cfg_we  in  1  configuration write strobe.
- cfg_timeout  in  CNT_W  cycles from arm to WARN.
- cfg_window  in  CNT_W  cycles from arm until the window opens.
- cfg_err  out  1  one-cycle pulse when a configuration write is rejected.
- kick_valid  in  1  kick strobe.
- kick_key  in  KEY_W  key presented with the kick.
- kick_ack  out  1  one-cycle pulse when a good kick is accepted.
- kick_err  out  1  one-cycle pulse on an early or bad-key kick.
- warn_irq  out  1  high while in WARN.
- timeout  out  1  high while in EXPIRED; sticky until reset.
- cause  out  2  expiry cause, sticky: 0 none, 1 timeout, 2 early kick, 3 bad key.
- state  out  3  current FSM state encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on port reset.
- Reset values:
  - state=DISABLED, cnt=0, gcnt=0.
  - timeout_r = all ones, window_r = 0.
  - All outputs 0, cause=0.
- States: DISABLED=0, CLOSED=1, OPEN=2, WARN=3, EXPIRED=4.
- Configuration:
  - Writes are accepted only in DISABLED.
  - cfg_timeout==0 → rejected: cfg_err pulse, registers unchanged.
  - cfg_window >= cfg_timeout → window_r=0 (no closed window), timeout_r written.
  - cfg_we in any other state → cfg_err pulse, ignored.
- Arm:
  - DISABLED & enable → cnt=0.
  - Next state is CLOSED if window_r!=0, else OPEN.
  - The first active cycle has cnt=0.
- Counting:
  - cnt increments by 1 every cycle in CLOSED and OPEN.
  - cnt never wraps, because the transitions below fire first.
- CLOSED:
  - cnt+1==window_r → OPEN.
  - Any kick_valid → EXPIRED, cause=2, kick_err.
- OPEN:
  - Good kick (kick_valid & kick_key==KICK_KEY) → kick_ack, cnt=0, re-arm as on arm.
  - cnt+1==timeout_r with no good kick → WARN, gcnt=0.
- Cycle arithmetic: arm to WARN entry is exactly timeout_r cycles. The window covers cycles window_r..timeout_r-1 after arm.
- WARN:
  - warn_irq=1; gcnt increments each cycle.
  - Good kick → kick_ack, re-arm.
  - gcnt==GRACE-1 with no good kick → EXPIRED, cause=1.
- Bad key: kick_valid with kick_key!=KICK_KEY in CLOSED/OPEN/WARN → EXPIRED, cause=3, kick_err.
- EXPIRED:
  - timeout=1; cause is held.
  - Kicks are ignored (no ack, no err).
  - Exit only via reset.
- DISABLED: kicks are ignored and no pulses are generated.
- Disable:
  - LOCK_EN=0 and enable low in CLOSED/OPEN/WARN → DISABLED, cnt=0. This has priority over a simultaneous kick.
  - LOCK_EN=1: enable is ignored once armed.
- Simultaneous events:
  - Good kick on the cycle cnt+1==timeout_r → kick wins; no WARN.
  - Good kick on the last GRACE cycle → kick wins.
  - Early kick on the cycle the window would open (cnt+1==window_r in CLOSED) → still early (cause=2).
- Reset mid-operation: any state → DISABLED next cycle; configuration reverts to reset values.
- Registered outputs:
  - warn_irq, timeout and state are registered; they change the cycle after the transition condition.
  - kick_ack, kick_err and cfg_err are registered one-cycle pulses, one cycle after the stimulus.

Decomposition:
- Package watchdog_pkg holds:
  - wd_state_t enum (5 states, 3-bit).
  - wd_cause_t codes (2-bit).
  - Default KICK_KEY constant.
- Sub-module wd_counter:
  - CNT_W-bit up-counter with synchronous clear, count enable, and terminal-compare input.
  - Output match = (cnt+1==cmp).
  - Instantiated twice: main counter, and grace counter with cmp=GRACE.

Test Plan:
1. Config timeout=4, window=2, then enable → CLOSED at cycles 0-1, OPEN at 2-3, warn_irq=1 from cycle 4 for 4 cycles, then timeout=1, cause=1.
2. Same config; good kick (key A5) at cycle 3 → kick_ack next cycle, cnt=0, CLOSED; no warn_irq for the next 4 cycles.
3. Same config; kick with key A5 at cycle 1 → kick_err pulse, EXPIRED, cause=2; later kicks produce no pulses.
4. Kick with key 3C while OPEN → kick_err, EXPIRED, cause=3; reset asserted for 1 cycle → state=0, timeout=0, cause=0.
5. cfg_timeout=0 → cfg_err, and an arm still gives WARN after 15 cycles. cfg_we while armed → cfg_err, timing unchanged. cfg_window=6 with cfg_timeout=5 → arm goes straight to OPEN.
6. Good kick on the cycle cnt+1==timeout_r, and on the last WARN cycle → kick_ack, no expiry. With LOCK_EN=0, dropping enable in OPEN → DISABLED.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared types and constants for the windowed watchdog supervisor.
package watchdog_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_CLOSED   = 3'd1,
    ST_OPEN     = 3'd2,
    ST_WARN     = 3'd3,
    ST_EXPIRED  = 3'd4
  } wd_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TIMEOUT = 2'd1,
    CAUSE_EARLY   = 2'd2,
    CAUSE_BADKEY  = 2'd3
  } wd_cause_t;

  localparam logic [7:0] WD_KICK_KEY = 8'hA5;

endpackage

// File: rtl/wd_counter.sv
// W-bit up-counter with synchronous clear/enable and a one-ahead terminal compare.
module wd_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         match
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Widened by one bit so an all-ones count never aliases to a match on zero.
  assign match = (({1'b0, cnt} + {{W{1'b0}}, 1'b1}) == {1'b0, cmp});

endmodule

// File: rtl/watchdog_supervisor.sv
// Windowed watchdog: arm, closed/open kick window, warning grace period, sticky expiry.
module watchdog_supervisor
  import watchdog_pkg::*;
#(
  parameter int unsigned       CNT_W    = 4,
  parameter int unsigned       KEY_W    = 8,
  parameter logic [KEY_W-1:0]  KICK_KEY = KEY_W'(WD_KICK_KEY),
  parameter int unsigned       GRACE    = 4,
  parameter bit                LOCK_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  output logic             cfg_err,
  input  logic             kick_valid,
  input  logic [KEY_W-1:0] kick_key,
  output logic             kick_ack,
  output logic             kick_err,
  output logic             warn_irq,
  output logic             timeout,
  output logic [1:0]       cause,
  output logic [2:0]       state
);

  wd_state_t        st, nxt, arm_st;
  wd_cause_t        cause_r;
  logic [CNT_W-1:0] timeout_r, window_r, cnt_cmp, grace_cmp;
  logic             good_kick, bad_kick, armed, dis_req, rearm;
  logic             cnt_clr, cnt_en, cnt_match, gcnt_clr, gcnt_en, gcnt_match;

  assign grace_cmp = CNT_W'(GRACE);
  assign arm_st    = (window_r != '0) ? ST_CLOSED : ST_OPEN;

  always_comb begin
    good_kick = kick_valid && (kick_key == KICK_KEY);
    bad_kick  = kick_valid && (kick_key != KICK_KEY);
    armed     = st inside {ST_CLOSED, ST_OPEN, ST_WARN};
    dis_req   = (LOCK_EN == 1'b0) && !enable && armed;
    rearm     = armed && !dis_req && good_kick && (st != ST_CLOSED);
    cnt_clr   = (st == ST_DISABLED) || dis_req || rearm;
    cnt_en    = (st == ST_CLOSED) || (st == ST_OPEN);
    gcnt_clr  = (st != ST_WARN);
    gcnt_en   = (st == ST_WARN);
    cnt_cmp   = (st == ST_CLOSED) ? window_r : timeout_r;

    nxt = st;
    case (st)
      ST_DISABLED: if (enable) nxt = arm_st;
      ST_CLOSED, ST_OPEN, ST_WARN: begin
        // Disable beats kicks; kicks beat the counter-driven transitions.
        if (dis_req)                           nxt = ST_DISABLED;
        else if (rearm)                        nxt = arm_st;
        else if (kick_valid)                   nxt = ST_EXPIRED;
        else if (st == ST_CLOSED && cnt_match) nxt = ST_OPEN;
        else if (st == ST_OPEN && cnt_match)   nxt = ST_WARN;
        else if (st == ST_WARN && gcnt_match)  nxt = ST_EXPIRED;
      end
      default: nxt = st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_DISABLED;
      timeout_r <= '1;
      window_r  <= '0;
      cause_r   <= CAUSE_NONE;
      warn_irq  <= 1'b0;
      timeout   <= 1'b0;
      kick_ack  <= 1'b0;
      kick_err  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      st       <= nxt;
      warn_irq <= (nxt == ST_WARN);
      timeout  <= (nxt == ST_EXPIRED);
      kick_ack <= rearm;
      kick_err <= armed && !dis_req && kick_valid && !rearm;
      cfg_err  <= cfg_we && ((st != ST_DISABLED) || (cfg_timeout == '0));
      if (cfg_we && (st == ST_DISABLED) && (cfg_timeout != '0)) begin
        timeout_r <= cfg_timeout;
        window_r  <= (cfg_window >= cfg_timeout) ? '0 : cfg_window;
      end
      if (armed && !dis_req) begin
        if (bad_kick)                               cause_r <= CAUSE_BADKEY;
        else if (good_kick && st == ST_CLOSED)      cause_r <= CAUSE_EARLY;
        else if (!kick_valid && st == ST_WARN && gcnt_match) cause_r <= CAUSE_TIMEOUT;
      end
    end
  end

  wd_counter #(.W(CNT_W)) u_main_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cmp   (cnt_cmp),
    .match (cnt_match)
  );

  wd_counter #(.W(CNT_W)) u_grace_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (gcnt_clr),
    .en    (gcnt_en),
    .cmp   (grace_cmp),
    .match (gcnt_match)
  );

  assign state = st;
  assign cause = cause_r;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed vector-table bench for watchdog_supervisor, plus hand sequences for multi-cycle corners.
module tb_watchdog_supervisor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_timeout = '0;
  logic [3:0] cfg_window = '0;
  logic       kick_valid = 1'b0;
  logic [7:0] kick_key = '0;

  logic       cfg_err, kick_ack, kick_err, warn_irq, timeout;
  logic [1:0] cause;
  logic [2:0] state;
  logic       cfg_err2, kick_ack2, kick_err2, warn_irq2, timeout2;
  logic [1:0] cause2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  watchdog_supervisor #(.CNT_W(4), .KEY_W(8), .KICK_KEY(8'hA5), .GRACE(4), .LOCK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_timeout(cfg_timeout), .cfg_window(cfg_window), .cfg_err(cfg_err),
    .kick_valid(kick_valid), .kick_key(kick_key), .kick_ack(kick_ack),
    .kick_err(kick_err), .warn_irq(warn_irq), .timeout(timeout),
    .cause(cause), .state(state)
  );

  watchdog_supervisor #(.CNT_W(4), .KEY_W(8), .KICK_KEY(8'hA5), .GRACE(4), .LOCK_EN(1'b0)) dut_nolock (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we),
    .cfg_timeout(cfg_timeout), .cfg_window(cfg_window), .cfg_err(cfg_err2),
    .kick_valid(kick_valid), .kick_key(kick_key), .kick_ack(kick_ack2),
    .kick_err(kick_err2), .warn_irq(warn_irq2), .timeout(timeout2),
    .cause(cause2), .state(state2)
  );

  typedef struct {
    bit       rst, en, we, kv;
    bit [3:0] ct, cw;
    bit [7:0] key;
    int       e_st, e_warn, e_to, e_cause, e_ack, e_kerr, e_cerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit en, input bit we, input bit [3:0] ct,
                     input bit [3:0] cw, input bit kv, input bit [7:0] key,
                     input int st, input int w, input int to, input int ca,
                     input int ack, input int kerr, input int cerr);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.ct = ct; v.cw = cw; v.kv = kv; v.key = key;
    v.e_st = st; v.e_warn = w; v.e_to = to; v.e_cause = ca;
    v.e_ack = ack; v.e_kerr = kerr; v.e_cerr = cerr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; kick_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic cfg(input bit [3:0] t, input bit [3:0] w);
    cfg_we = 1'b1; cfg_timeout = t; cfg_window = w;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    // Test 1: natural timeout through CLOSED, OPEN, WARN, EXPIRED.
    add(1,0,0,0,0,0,8'h00, 0,0,0,0,0,0,0);
    add(0,0,1,4,2,0,8'h00, 0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,8'h00, 3,1,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 4,0,1,1,0,0,0);
    add(0,1,0,0,0,1,8'hA5, 4,0,1,1,0,0,0);
    // Test 2: good kick on the OPEN terminal cycle, then on the last WARN cycle.
    add(1,0,0,0,0,0,8'h00, 0,0,0,0,0,0,0);
    add(0,0,1,4,2,0,8'h00, 0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    add(0,1,0,0,0,1,8'hA5, 1,0,0,0,1,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,8'h00, 3,1,0,0,0,0,0);
    add(0,1,0,0,0,1,8'hA5, 1,0,0,0,1,0,0);
    // Test 3: early kick on the cycle the window would open.
    add(1,0,0,0,0,0,8'h00, 0,0,0,0,0,0,0);
    add(0,0,1,4,2,0,8'h00, 0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,1,8'hA5, 4,0,1,2,0,1,0);
    add(0,1,0,0,0,1,8'hA5, 4,0,1,2,0,0,0);
    add(0,1,0,0,0,1,8'h3C, 4,0,1,2,0,0,0);
    // Test 4: bad key while OPEN, then reset clears everything.
    add(1,0,0,0,0,0,8'h00, 0,0,0,0,0,0,0);
    add(0,0,1,4,2,0,8'h00, 0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,8'h00, 2,0,0,0,0,0,0);
    add(0,1,0,0,0,1,8'h3C, 4,0,1,3,0,1,0);
    add(1,1,0,0,0,0,8'h00, 0,0,0,0,0,0,0);

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; cfg_we = tbl[i].we;
      cfg_timeout = tbl[i].ct; cfg_window = tbl[i].cw;
      kick_valid = tbl[i].kv; kick_key = tbl[i].key;
      tick();
      chk($sformatf("v%0d.state", i),    int'(state),    tbl[i].e_st);
      chk($sformatf("v%0d.warn_irq", i), int'(warn_irq), tbl[i].e_warn);
      chk($sformatf("v%0d.timeout", i),  int'(timeout),  tbl[i].e_to);
      chk($sformatf("v%0d.cause", i),    int'(cause),    tbl[i].e_cause);
      chk($sformatf("v%0d.kick_ack", i), int'(kick_ack), tbl[i].e_ack);
      chk($sformatf("v%0d.kick_err", i), int'(kick_err), tbl[i].e_kerr);
      chk($sformatf("v%0d.cfg_err", i),  int'(cfg_err),  tbl[i].e_cerr);
    end
    reset = 1'b0; kick_valid = 1'b0;

    // Test 5a: zero timeout rejected, defaults give WARN after 15 cycles; write while armed rejected.
    do_reset();
    cfg(4'd0, 4'd0);
    chk("cfg_zero.cfg_err", int'(cfg_err), 1);
    tick();
    chk("cfg_zero.pulse_end", int'(cfg_err), 0);
    enable = 1'b1;
    tick();
    chk("default.arm_open", int'(state), 2);
    for (int i = 1; i <= 14; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1; cfg_timeout = 4'd2; cfg_window = 4'd0;
      end
      tick();
      cfg_we = 1'b0;
      if (i == 3) chk("cfg_armed.cfg_err", int'(cfg_err), 1);
    end
    chk("default.still_open", int'(state), 2);
    tick();
    chk("default.warn_state", int'(state), 3);
    chk("default.warn_irq", int'(warn_irq), 1);

    // Test 5b: window >= timeout means no closed window.
    do_reset();
    cfg(4'd5, 4'd6);
    chk("win_ge.cfg_err", int'(cfg_err), 0);
    enable = 1'b1;
    tick();
    chk("win_ge.arm_open", int'(state), 2);
    for (int i = 0; i < 4; i++) tick();
    chk("win_ge.still_open", int'(state), 2);
    tick();
    chk("win_ge.warn", int'(state), 3);

    // Test 6: enable drop with a simultaneous good kick, locked vs unlocked instance.
    do_reset();
    cfg(4'd4, 4'd2);
    enable = 1'b1;
    tick(); tick(); tick();
    chk("drop.pre_open", int'(state2), 2);
    enable = 1'b0; kick_valid = 1'b1; kick_key = 8'hA5;
    tick();
    kick_valid = 1'b0;
    chk("drop.nolock_state", int'(state2), 0);
    chk("drop.nolock_ack", int'(kick_ack2), 0);
    chk("drop.lock_state", int'(state), 1);
    chk("drop.lock_ack", int'(kick_ack), 1);
    tick();
    chk("drop.nolock_stays", int'(state2), 0);
    chk("drop.lock_stays", int'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
